// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between the decode/forwarding side and the ID/EX operand stage.
// slave = stage view, master = driver/observer view.
interface id_ex_operand_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5
);
   logic             id_valid;
   logic [XLEN-1:0]  id_rs_data;
   logic [XLEN-1:0]  id_rt_data;
   logic [XLEN-1:0]  id_imm;
   logic [4:0]       id_shamt;
   logic [3:0]       id_alu_ctrl;
   logic             id_alusrc;
   logic             id_uses_rt;
   logic [RADDR-1:0] id_rs_addr;
   logic [RADDR-1:0] id_rt_addr;
   logic [RADDR-1:0] id_rd_addr;
   logic             id_regwrite;
   logic             id_memread;
   logic             id_memwrite;
   logic             id_memtoreg;
   logic             stall;
   logic             flush;
   logic             exm_regwrite;
   logic [RADDR-1:0] exm_rd;
   logic [XLEN-1:0]  exm_result;
   logic             mwb_regwrite;
   logic [RADDR-1:0] mwb_rd;
   logic [XLEN-1:0]  mwb_result;
   logic [XLEN-1:0]  alu_a;
   logic [XLEN-1:0]  alu_b;
   logic [4:0]       alu_shamt;
   logic [3:0]       alu_control;
   logic [XLEN-1:0]  ex_store_data;
   logic [RADDR-1:0] ex_rd;
   logic             ex_valid;
   logic             ex_regwrite;
   logic             ex_memread;
   logic             ex_memwrite;
   logic             ex_memtoreg;
   logic             load_use_stall;

   modport slave (
      input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_ctrl, id_alusrc,
             id_uses_rt, id_rs_addr, id_rt_addr, id_rd_addr, id_regwrite, id_memread,
             id_memwrite, id_memtoreg, stall, flush, exm_regwrite, exm_rd, exm_result,
             mwb_regwrite, mwb_rd, mwb_result,
      output alu_a, alu_b, alu_shamt, alu_control, ex_store_data, ex_rd, ex_valid,
             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
   );

   modport master (
      output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_ctrl, id_alusrc,
             id_uses_rt, id_rs_addr, id_rt_addr, id_rd_addr, id_regwrite, id_memread,
             id_memwrite, id_memtoreg, stall, flush, exm_regwrite, exm_rd, exm_result,
             mwb_regwrite, mwb_rd, mwb_result,
      input  alu_a, alu_b, alu_shamt, alu_control, ex_store_data, ex_rd, ex_valid,
             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_stall
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand selection, forwarding and load-use detection.
// Define FORWARDING_EN to build the EX/MEM and MEM/WB forwarding muxes.
module id_ex_operand_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RADDR = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   id_ex_operand_stage_if.slave  bus
);

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  rs_data;
      logic [XLEN-1:0]  rt_data;
      logic [XLEN-1:0]  imm;
      logic [4:0]       shamt;
      logic [3:0]       ctrl;
      logic             alusrc;
      logic [RADDR-1:0] rs_addr;
      logic [RADDR-1:0] rt_addr;
      logic [RADDR-1:0] rd;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             memtoreg;
   } stage_t;

   stage_t          stage_q, stage_d;
   logic            load_use;
   logic [XLEN-1:0] rs_fwd, rt_fwd;

   // Decode slot reads the register an in-flight load has not yet produced.
   assign load_use = bus.id_valid & ~bus.flush & stage_q.valid & stage_q.memread &
                     (stage_q.rd != '0) &
                     ((stage_q.rd == bus.id_rs_addr) |
                      (bus.id_uses_rt & (stage_q.rd == bus.id_rt_addr)));

   always_comb begin
      stage_d = stage_q;
      if (bus.flush) begin
         stage_d = '0;
      end else if (bus.stall) begin
         stage_d = stage_q;
      end else if (load_use) begin
         stage_d = '0;
      end else begin
         stage_d.valid    = bus.id_valid;
         stage_d.rs_data  = bus.id_rs_data;
         stage_d.rt_data  = bus.id_rt_data;
         stage_d.imm      = bus.id_imm;
         stage_d.shamt    = bus.id_shamt;
         stage_d.ctrl     = bus.id_alu_ctrl;
         stage_d.alusrc   = bus.id_alusrc;
         stage_d.rs_addr  = bus.id_rs_addr;
         stage_d.rt_addr  = bus.id_rt_addr;
         stage_d.rd       = bus.id_rd_addr;
         stage_d.regwrite = bus.id_regwrite;
         stage_d.memread  = bus.id_memread;
         stage_d.memwrite = bus.id_memwrite;
         stage_d.memtoreg = bus.id_memtoreg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

`ifdef FORWARDING_EN
   // EX/MEM is younger than MEM/WB, so it takes priority; r0 is never forwarded.
   always_comb begin
      rs_fwd = stage_q.rs_data;
      if (bus.exm_regwrite && (bus.exm_rd != '0) && (bus.exm_rd == stage_q.rs_addr)) begin
         rs_fwd = bus.exm_result;
      end else if (bus.mwb_regwrite && (bus.mwb_rd != '0) &&
                   (bus.mwb_rd == stage_q.rs_addr)) begin
         rs_fwd = bus.mwb_result;
      end
   end

   always_comb begin
      rt_fwd = stage_q.rt_data;
      if (bus.exm_regwrite && (bus.exm_rd != '0) && (bus.exm_rd == stage_q.rt_addr)) begin
         rt_fwd = bus.exm_result;
      end else if (bus.mwb_regwrite && (bus.mwb_rd != '0) &&
                   (bus.mwb_rd == stage_q.rt_addr)) begin
         rt_fwd = bus.mwb_result;
      end
   end
`else
   assign rs_fwd = stage_q.rs_data;
   assign rt_fwd = stage_q.rt_data;

   logic unused_fwd;
   assign unused_fwd = ^{bus.exm_regwrite, bus.exm_rd, bus.exm_result, bus.mwb_regwrite,
                         bus.mwb_rd, bus.mwb_result, stage_q.rs_addr, stage_q.rt_addr};
`endif

   assign bus.alu_a          = rs_fwd;
   assign bus.alu_b          = stage_q.alusrc ? stage_q.imm : rt_fwd;
   assign bus.ex_store_data  = rt_fwd;
   assign bus.alu_shamt      = stage_q.shamt;
   assign bus.alu_control    = stage_q.ctrl;
   assign bus.ex_rd          = stage_q.rd;
   assign bus.ex_valid       = stage_q.valid;
   assign bus.ex_regwrite    = stage_q.regwrite;
   assign bus.ex_memread     = stage_q.memread;
   assign bus.ex_memwrite    = stage_q.memwrite;
   assign bus.ex_memtoreg    = stage_q.memtoreg;
   assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized bench for id_ex_operand_stage against a behavioural model of the stage.
// The model follows FORWARDING_EN the same way the build does.
module tb_id_ex_operand_stage;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   id_ex_operand_stage_if #(.XLEN(32), .RADDR(5)) bus ();

   id_ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the instruction sitting in EX.
   logic        m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mtr;
   logic [31:0] m_rs, m_rt, m_imm;
   logic [4:0]  m_shamt, m_rsa, m_rta, m_rd;
   logic [3:0]  m_ctrl;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef FORWARDING_EN
      if (bus.exm_regwrite && bus.exm_rd != 0 && bus.exm_rd == a) return bus.exm_result;
      if (bus.mwb_regwrite && bus.mwb_rd != 0 && bus.mwb_rd == a) return bus.mwb_result;
`endif
      return d;
   endfunction

   function automatic logic exp_lus();
      return bus.id_valid && !bus.flush && m_valid && m_mr && m_rd != 0 &&
             (m_rd == bus.id_rs_addr || (bus.id_uses_rt && m_rd == bus.id_rt_addr));
   endfunction

   task automatic model_clear();
      {m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mtr} = '0;
      {m_rs, m_rt, m_imm} = '0;
      {m_shamt, m_rsa, m_rta, m_rd, m_ctrl} = '0;
   endtask

   task automatic model_step();
      if (bus.flush) begin
         model_clear();
      end else if (bus.stall) begin
         // hold
      end else if (exp_lus()) begin
         model_clear();
      end else begin
         m_valid = bus.id_valid;     m_rs    = bus.id_rs_data;  m_rt  = bus.id_rt_data;
         m_imm   = bus.id_imm;       m_shamt = bus.id_shamt;    m_ctrl = bus.id_alu_ctrl;
         m_alusrc = bus.id_alusrc;   m_rsa   = bus.id_rs_addr;  m_rta = bus.id_rt_addr;
         m_rd    = bus.id_rd_addr;   m_rw    = bus.id_regwrite; m_mr  = bus.id_memread;
         m_mw    = bus.id_memwrite;  m_mtr   = bus.id_memtoreg;
      end
   endtask

   // Model and DUT both advance on the same edge; inputs are stable around it.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      #1;
      check_eq({tag, ".alu_a"}, bus.alu_a, fwd(m_rsa, m_rs));
      check_eq({tag, ".alu_b"}, bus.alu_b, m_alusrc ? m_imm : fwd(m_rta, m_rt));
      check_eq({tag, ".store"}, bus.ex_store_data, fwd(m_rta, m_rt));
      check_eq({tag, ".shamt"}, {27'd0, bus.alu_shamt}, {27'd0, m_shamt});
      check_eq({tag, ".ctrl"}, {28'd0, bus.alu_control}, {28'd0, m_ctrl});
      check_eq({tag, ".rd"}, {27'd0, bus.ex_rd}, {27'd0, m_rd});
      check_eq({tag, ".ctl"},
               {27'd0, bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                bus.ex_memtoreg},
               {27'd0, m_valid, m_rw, m_mr, m_mw, m_mtr});
      check_eq({tag, ".lus"}, {31'd0, bus.load_use_stall}, {31'd0, exp_lus()});
   endtask

   task automatic clear_inputs();
      bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
      bus.id_shamt = 0; bus.id_alu_ctrl = 0; bus.id_alusrc = 0; bus.id_uses_rt = 0;
      bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
      bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
      bus.stall = 0; bus.flush = 0;
      bus.exm_regwrite = 0; bus.exm_rd = 0; bus.exm_result = 0;
      bus.mwb_regwrite = 0; bus.mwb_rd = 0; bus.mwb_result = 0;
   endtask

   task automatic drive_rand();
      logic [3:0] ops [7];
      ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12};
      bus.id_valid     = ($urandom_range(0, 9) != 0);
      bus.id_rs_data   = $urandom;
      bus.id_rt_data   = $urandom;
      bus.id_imm       = $urandom;
      bus.id_shamt     = 5'($urandom);
      bus.id_alu_ctrl  = ops[$urandom_range(0, 6)];
      bus.id_alusrc    = 1'($urandom);
      bus.id_uses_rt   = 1'($urandom);
      bus.id_rs_addr   = 5'($urandom_range(0, 3));
      bus.id_rt_addr   = 5'($urandom_range(0, 3));
      bus.id_rd_addr   = 5'($urandom_range(0, 3));
      bus.id_regwrite  = 1'($urandom);
      bus.id_memread   = ($urandom_range(0, 2) == 0);
      bus.id_memwrite  = 1'($urandom);
      bus.id_memtoreg  = 1'($urandom);
      bus.stall        = ($urandom_range(0, 7) == 0);
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.exm_regwrite = 1'($urandom);
      bus.exm_rd       = 5'($urandom_range(0, 3));
      bus.exm_result   = $urandom;
      bus.mwb_regwrite = 1'($urandom);
      bus.mwb_rd       = 5'($urandom_range(0, 3));
      bus.mwb_result   = $urandom;
   endtask

   logic [31:0] held_a, held_b;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      clear_inputs();
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state.
      check_all("reset");
      check_eq("reset.valid", {31'd0, bus.ex_valid}, 32'd0);
      check_eq("reset.alu_a", bus.alu_a, 32'd0);
      check_eq("reset.alu_b", bus.alu_b, 32'd0);
      check_eq("reset.lus", {31'd0, bus.load_use_stall}, 32'd0);

      // ADD capture.
      bus.id_valid = 1; bus.id_alu_ctrl = 4; bus.id_rs_data = 5; bus.id_rt_data = 7;
      bus.id_rs_addr = 2; bus.id_rt_addr = 3; bus.id_rd_addr = 4; bus.id_regwrite = 1;
      tick();
      clear_inputs();
      check_all("add");
      check_eq("add.alu_a", bus.alu_a, 32'd5);
      check_eq("add.alu_b", bus.alu_b, 32'd7);
      check_eq("add.ctrl", {28'd0, bus.alu_control}, 32'd4);
      check_eq("add.valid", {31'd0, bus.ex_valid}, 32'd1);

      // Forwarding priority on rs=8.
      bus.id_valid = 1; bus.id_rs_addr = 8; bus.id_rs_data = 32'h11; bus.id_alu_ctrl = 4;
      tick();
      clear_inputs();
      bus.exm_regwrite = 1; bus.exm_rd = 8; bus.exm_result = 32'h100;
      bus.mwb_regwrite = 1; bus.mwb_rd = 8; bus.mwb_result = 32'h200;
      check_all("fwd_both");
      bus.exm_regwrite = 0;
      check_all("fwd_mwb");
      bus.exm_regwrite = 1; bus.exm_rd = 0;
      check_all("fwd_rd0");
      clear_inputs();

      // Load-use: LW rd=9 in EX, decode reads rs=9.
      bus.id_valid = 1; bus.id_memread = 1; bus.id_memtoreg = 1; bus.id_regwrite = 1;
      bus.id_rd_addr = 9; bus.id_rs_addr = 1;
      tick();
      clear_inputs();
      bus.id_valid = 1; bus.id_rs_addr = 9; bus.id_alu_ctrl = 6; bus.id_regwrite = 1;
      bus.id_rd_addr = 10; bus.id_rs_data = 32'h33;
      check_all("lu_detect");
      check_eq("lu.lus", {31'd0, bus.load_use_stall}, 32'd1);
      tick();
      check_all("lu_bubble");
      check_eq("lu.valid", {31'd0, bus.ex_valid}, 32'd0);
      check_eq("lu.rw", {31'd0, bus.ex_regwrite}, 32'd0);
      tick();
      check_all("lu_capture");
      check_eq("lu.recapture", {31'd0, bus.ex_valid}, 32'd1);

      // Stall for three cycles while decode changes.
      held_a = bus.alu_a;
      held_b = bus.alu_b;
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         drive_rand();
         bus.stall = 1; bus.flush = 0;
         bus.exm_regwrite = 0; bus.mwb_regwrite = 0;
         tick();
         bus.exm_regwrite = 0; bus.mwb_regwrite = 0;
         check_all("stall");
         check_eq("stall.alu_a", bus.alu_a, held_a);
         check_eq("stall.alu_b", bus.alu_b, held_b);
      end
      bus.stall = 1; bus.flush = 1;
      tick();
      check_all("flush_stall");
      check_eq("flush.valid", {31'd0, bus.ex_valid}, 32'd0);
      clear_inputs();

      // SLL with immediate operand B.
      bus.id_valid = 1; bus.id_alu_ctrl = 2; bus.id_shamt = 4; bus.id_alusrc = 1;
      bus.id_imm = 32'hFFFF_FFF0; bus.id_rt_addr = 3; bus.id_rt_data = 32'hABCD;
      tick();
      clear_inputs();
      bus.mwb_regwrite = 1; bus.mwb_rd = 3; bus.mwb_result = 32'h5151;
      check_all("sll");
      check_eq("sll.shamt", {27'd0, bus.alu_shamt}, 32'd4);
      check_eq("sll.alu_b", bus.alu_b, 32'hFFFF_FFF0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive_rand();
         check_all("rand");
         tick();
      end

      // Asynchronous reset mid-operation.
      drive_rand();
      bus.flush = 0; bus.stall = 0;
      #1 rst_n = 1'b0;
      model_clear();
      check_all("midreset");
      check_eq("midreset.valid", {31'd0, bus.ex_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         drive_rand();
         check_all("rand2");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and EX-stage operand selector that drives the ALU's a, b, shamt and 4-bit control inputs.
- Captures decoded operands and control each cycle.
- Applies EX/MEM and MEM/WB forwarding, selects register or immediate for operand B, and detects load-use hazards.
- Handles stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data  in  XLEN  rs register-file read value
- id_rt_data  in  XLEN  rt register-file read value
- id_imm  in  XLEN  sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_alu_ctrl  in  4  ALU op: 0 AND, 1 OR, 2 SLL, 4 ADD, 6 SUB, 7 SLT, 12 NOR
- id_alusrc  in  1  1 = operand B from immediate
- id_uses_rt  in  1  instruction reads rt
- id_rs_addr, id_rt_addr, id_rd_addr  in  RADDR each  source and destination register numbers
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  decoded control
- stall  in  1  hold stage contents
- flush  in  1  replace next contents with a bubble
- exm_regwrite  in  1  EX/MEM writes a register
- exm_rd  in  RADDR  EX/MEM destination
- exm_result  in  XLEN  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB writes a register
- mwb_rd  in  RADDR  MEM/WB destination
- mwb_result  in  XLEN  MEM/WB writeback value
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_shamt  out  5  ALU shamt
- alu_control  out  4  ALU control
- ex_store_data  out  XLEN  forwarded rt for stores
- ex_rd  out  RADDR  destination, forwarded downstream
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control
- load_use_stall  out  1  request for upstream PC/IF/ID to hold

Behaviour:
- Reset (rst_n low, async):
  - All stage registers clear to 0; the stage is a bubble.
  - Resulting outputs: ex_valid=0, alu_control=0, all write/mem enables 0, ex_rd=0.
  - alu_a, alu_b and ex_store_data are 0, unless the forwarding inputs match register 0. They cannot, because rd 0 is never forwarded.
- Register update at each rising clk, in priority order:
  1. flush=1: load a bubble. Every field is 0, including ex_valid and enables.
  2. stall=1: hold all fields.
  3. load_use_stall=1: load a bubble. Upstream holds the instruction, which re-enters next cycle.
  4. Otherwise: capture all id_* inputs.
- Latency: a decode-slot value appears at the ALU inputs 1 cycle after capture.
- Forwarding (combinational, applied to the registered rs/rt, separately for each operand):
  - If exm_regwrite, exm_rd!=0 and exm_rd equals the source address: use exm_result.
  - Else if mwb_regwrite, mwb_rd!=0 and mwb_rd equals the source address: use mwb_result.
  - Else use the registered data.
  - EX/MEM always wins when both stages match.
- Operand outputs:
  - alu_a = forwarded rs.
  - alu_b = registered alusrc ? registered imm : forwarded rt.
  - ex_store_data = forwarded rt, regardless of alusrc.
  - alu_shamt and alu_control are the registered values, never forwarded.
- load_use_stall (combinational) = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs_addr | (id_uses_rt & ex_rd==id_rt_addr)).
  - Requires id_valid=1.
  - Forced to 0 while flush=1.
- Bubble contents: alu_control=0 (AND), so the ALU's zero flag may assert on a bubble. Downstream qualifies it with ex_valid.
- Reset mid-operation discards the in-flight instruction. No partial state survives.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: forwarding muxes present as described above.
- Undefined:
  - Forwarding logic is absent: alu_a = registered rs, forwarded rt = registered rt.
  - exm_*/mwb_* inputs remain as ports but are ignored.
  - load_use_stall behaviour is unchanged. Software schedules other RAW gaps.

Test Plan:
- Reset release, no stimulus -> ex_valid=0, alu_control=0, alu_a=alu_b=0, load_use_stall=0.
- Capture ADD (id_alu_ctrl=4, rs_data=5, rt_data=7, alusrc=0) -> next cycle alu_a=5, alu_b=7, alu_control=4, ex_valid=1.
- Registered rs=8, exm_regwrite=1, exm_rd=8, exm_result=0x100, mwb_rd=8, mwb_result=0x200 -> alu_a=0x100. Drop exm_regwrite -> alu_a=0x200. Set exm_rd=0 -> no EX/MEM forward.
- EX holds LW with rd=9, decode reads rs=9 -> load_use_stall=1; next cycle ex_valid=0 and enables 0; instruction captured one cycle later.
- stall=1 for 3 cycles with changing id_* -> outputs unchanged. flush=1 together with stall=1 -> bubble on next edge.
- Capture SLL (ctrl=2, shamt=4, alusrc=1, imm=0xFFFF_FFF0) -> alu_shamt=4, alu_b=0xFFFF_FFF0, ex_store_data = forwarded rt.
